// File: rtl/sample_input_debouncer_pkg.sv
// Shared definitions for the switch input stage feeding the `sample` block.
package sample_input_debouncer_pkg;

    localparam int unsigned SAMPLE_IN_W        = 4;
    localparam int unsigned SAMPLE_CLK_HZ      = 50_000_000;
    localparam int unsigned SAMPLE_DEBOUNCE_MS = 10;

    // Stable cycles needed to accept a new switch level
    localparam int unsigned DEBOUNCE_CNT_MAX = (SAMPLE_CLK_HZ / 1000) * SAMPLE_DEBOUNCE_MS;

    typedef struct packed {
        logic stable;
        logic rise;
        logic fall;
    } db_bit_t;

endpackage

// File: rtl/sample_input_debouncer_debounce_bit.sv
// One switch bit: synchroniser chain, qualification counter and stable level with edge strobes.
module sample_input_debouncer_debounce_bit
    import sample_input_debouncer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_MAX     = 8
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    raw_i,
    output db_bit_t bit_o,
    output logic    accept_c_o
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    db_bit_t                bit_q, bit_d;
    logic                   sync_out;
    logic                   accept_c;

    // Counter only runs while the synced level disagrees with the accepted one
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
        sync_out = sync_q[SYNC_STAGES-1];
        accept_c = (sync_out != bit_q.stable) && (cnt_q == CNT_W'(CNT_MAX - 1));
        cnt_d    = '0;
        bit_d    = bit_q;
        bit_d.rise = 1'b0;
        bit_d.fall = 1'b0;
        if (sync_out != bit_q.stable) begin
            if (accept_c) begin
                bit_d.stable = sync_out;
                bit_d.rise   = sync_out;
                bit_d.fall   = ~sync_out;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            bit_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            bit_q  <= bit_d;
        end
    end

    assign bit_o      = bit_q;
    assign accept_c_o = accept_c;

endmodule

// File: rtl/sample_input_debouncer.sv
// Synchronises and debounces the raw board switches into the {x,y,z,w} levels of `sample`,
// with per-bit edge strobes, a combined change strobe and a post-reset settle flag.
module sample_input_debouncer
    import sample_input_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH       = SAMPLE_IN_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_MAX     = DEBOUNCE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             settled
);

    localparam int unsigned SETTLE_CYCLES = CNT_MAX + SYNC_STAGES;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES);

    db_bit_t             bit_s [WIDTH];
    logic [WIDTH-1:0]    accept_c;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic                settled_q, settled_d;
    logic                changed_q, changed_d;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        sample_input_debouncer_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_MAX     (CNT_MAX)
        ) u_bit (
            .clk_i      (clk),
            .rst_i      (rst),
            .raw_i      (sw_raw[g]),
            .bit_o      (bit_s[g]),
            .accept_c_o (accept_c[g])
        );

        assign sw_stable[g] = bit_s[g].stable;
        assign rise[g]      = bit_s[g].rise;
        assign fall[g]      = bit_s[g].fall;
    end

    // changed is registered from the same accept condition so it lines up with rise/fall
    always_comb begin
        changed_d    = |accept_c;
        settle_cnt_d = settle_cnt_q;
        settled_d    = settled_q;
        if (!settled_q) begin
            if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                settled_d = 1'b1;
            end else begin
                settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_q <= '0;
            settled_q    <= 1'b0;
            changed_q    <= 1'b0;
        end else begin
            settle_cnt_q <= settle_cnt_d;
            settled_q    <= settled_d;
            changed_q    <= changed_d;
        end
    end

    assign changed = changed_q;
    assign settled = settled_q;

endmodule

// File: tb/tb_sample_input_debouncer.sv
// Directed bench for sample_input_debouncer with CNT_MAX=8, SYNC_STAGES=2 (10-edge latency).
module tb_sample_input_debouncer;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic         settled;

    int n_tests;
    int n_fail;
    int chg_cnt;
    int b2b_cnt;
    logic         prev_chg;
    logic [W-1:0] rise_acc;
    logic [W-1:0] fall_acc;

    sample_input_debouncer #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .CNT_MAX     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .sw_stable (sw_stable),
        .rise      (rise),
        .fall      (fall),
        .changed   (changed),
        .settled   (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then observe strobes 1 time unit later
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (changed) chg_cnt++;
            if (changed && prev_chg) b2b_cnt++;
            prev_chg = changed;
            rise_acc |= rise;
            fall_acc |= fall;
        end
    endtask

    task automatic clear_acc();
        chg_cnt  = 0;
        rise_acc = '0;
        fall_acc = '0;
    endtask

    function automatic logic f_of(input logic [3:0] v);
        return (v[3] ^ (v[2] & v[1])) | ~v[0];
    endfunction

    initial begin
        logic [W-1:0] prev_v;
        int           exp_chg;
        n_tests  = 0;
        n_fail   = 0;
        b2b_cnt  = 0;
        prev_chg = 1'b0;
        clear_acc();
        rst    = 1'b1;
        sw_raw = '0;

        // 1: reset and settle timing
        tick(3);
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_changed", 32'(changed), 32'h0);
        chk("rst_settled", 32'(settled), 32'h0);
        rst = 1'b0;
        clear_acc();
        tick(9);
        chk("settle_e9", 32'(settled), 32'h0);
        tick(1);
        chk("settle_e10", 32'(settled), 32'h1);
        tick(3);
        chk("settle_hold", 32'(settled), 32'h1);
        chk("t1_no_chg", 32'(chg_cnt), 32'h0);

        // 2: 0000 -> 1010 accepted at edge 10
        clear_acc();
        sw_raw = 4'b1010;
        tick(9);
        chk("t2_e9_stable", 32'(sw_stable), 32'h0);
        tick(1);
        chk("t2_e10_stable", 32'(sw_stable), 32'ha);
        chk("t2_e10_rise", 32'(rise), 32'ha);
        chk("t2_e10_fall", 32'(fall), 32'h0);
        chk("t2_e10_chg", 32'(changed), 32'h1);
        tick(1);
        chk("t2_e11_rise", 32'(rise), 32'h0);
        chk("t2_e11_chg", 32'(changed), 32'h0);
        chk("t2_chg_cnt", 32'(chg_cnt), 32'h1);

        // 3: 7-cycle glitch on bit0 is rejected
        clear_acc();
        sw_raw = 4'b1011;
        tick(7);
        sw_raw = 4'b1010;
        tick(20);
        chk("t3_stable", 32'(sw_stable), 32'ha);
        chk("t3_chg_cnt", 32'(chg_cnt), 32'h0);
        chk("t3_rise_acc", 32'(rise_acc), 32'h0);
        chk("t3_fall_acc", 32'(fall_acc), 32'h0);

        // 4: drop bit3, then bounce it back up
        clear_acc();
        sw_raw = 4'b0010;
        tick(12);
        chk("t4_drop_stable", 32'(sw_stable), 32'h2);
        chk("t4_drop_fall", 32'(fall_acc), 32'h8);
        clear_acc();
        begin
            logic [6:0] bounce;
            bounce = 7'b1110010;
            for (int i = 6; i >= 0; i--) begin
                sw_raw = {bounce[i], 3'b010};
                tick(1);
            end
        end
        sw_raw = 4'b1010;
        tick(9);
        chk("t4_e9_bit3", 32'(sw_stable[3]), 32'h0);
        tick(1);
        chk("t4_e10_bit3", 32'(sw_stable[3]), 32'h1);
        chk("t4_e10_rise", 32'(rise), 32'h8);
        tick(12);
        chk("t4_rise_acc", 32'(rise_acc), 32'h8);
        chk("t4_chg_cnt", 32'(chg_cnt), 32'h1);

        // 5: reset mid-count, then requalify from reset release
        sw_raw = 4'b1111;
        tick(7);
        rst = 1'b1;
        tick(1);
        chk("t5_rst_stable", 32'(sw_stable), 32'h0);
        chk("t5_rst_rise", 32'(rise), 32'h0);
        chk("t5_rst_fall", 32'(fall), 32'h0);
        chk("t5_rst_chg", 32'(changed), 32'h0);
        chk("t5_rst_settled", 32'(settled), 32'h0);
        rst = 1'b0;
        clear_acc();
        tick(9);
        chk("t5_e9_stable", 32'(sw_stable), 32'h0);
        chk("t5_e9_settled", 32'(settled), 32'h0);
        tick(1);
        chk("t5_e10_stable", 32'(sw_stable), 32'hf);
        chk("t5_e10_rise", 32'(rise), 32'hf);
        chk("t5_e10_settled", 32'(settled), 32'h1);
        chk("t5_e10_chg", 32'(changed), 32'h1);
        tick(1);
        chk("t5_e11_rise", 32'(rise), 32'h0);

        // 6: sweep all inputs into the sample function
        clear_acc();
        prev_v  = 4'b1111;
        exp_chg = 0;
        for (int v = 0; v < 16; v++) begin
            sw_raw = 4'(v);
            if (4'(v) != prev_v) exp_chg++;
            prev_v = 4'(v);
            tick(12);
            chk($sformatf("t6_stable_%0d", v), 32'(sw_stable), 32'(v));
            chk($sformatf("t6_f_%0d", v), 32'(f_of(sw_stable)), 32'(f_of(4'(v))));
        end
        chk("t6_chg_cnt", 32'(chg_cnt), 32'(exp_chg));
        chk("no_b2b_changed", 32'(b2b_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
